// File: rtl/axi4full_sub_pkg.sv
// axi4full_sub_pkg: shared types and constants for the AXI4-full subordinate memory.
// Provides response codes, write/read FSM state encodings and the byte-offset helper.
package axi4full_sub_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    localparam int OFF_DW32 = 2;
    localparam int OFF_DW64 = 3;

    // log2 of the bytes per data word (only 32 and 64 bit buses exist)
    function automatic int byte_off(input int dw);
        return (dw == 64) ? OFF_DW64 : OFF_DW32;
    endfunction

endpackage

// File: rtl/axi4full_sub_mem_if.sv
// axi4full_sub_mem_if: AXI4-full bus (AW, W, B, AR, R channels, INCR only).
// Ports: DW-bit data, AW-bit byte address; master drives valids, slave drives readies.
interface axi4full_sub_mem_if #(
    parameter int DW = 32,
    parameter int AW = 12
) ();
    logic [AW-1:0]   AWADDR;
    logic [7:0]      AWLEN;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic [7:0]      ARLEN;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWADDR, AWLEN, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARLEN, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4full_sub_bram.sv
// axi4full_sub_bram: word array with a byte-enable synchronous write port
// and one asynchronous read port. Ports: i_clk, i_we/i_waddr/i_wdata/i_wstrb, i_raddr -> o_rdata.
module axi4full_sub_bram #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [IW-1:0]   i_waddr,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic [IW-1:0]   i_raddr,
    output logic [DW-1:0]   o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    // contents survive reset by design, so no reset branch here
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi4full_sub_mem.sv
// axi4full_sub_mem: AXI4-full subordinate memory, INCR bursts, ordering AR->R and AW->W->B.
// Ports: S_AXI_ACLK, S_AXI_ARESETN (async, active-low), s_axi (slave modport of axi4full_sub_mem_if).
// Option: define AXI4FULL_SUB_BACKPRESSURE_EN to throttle AWREADY/WREADY/ARREADY with an LFSR.
module axi4full_sub_mem
    import axi4full_sub_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int MEM_WORDS          = 256
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    axi4full_sub_mem_if.slave s_axi
);
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int OFF = byte_off(DW);
    localparam int WA  = AW - OFF;
    localparam int IW  = $clog2(MEM_WORDS);
    localparam logic [31:0] MW = 32'(MEM_WORDS);

    function automatic logic in_range(input logic [WA-1:0] a);
        return 32'(a) < MW;
    endfunction

    logic          r_live;
    logic          w_bp;
    logic          w_unused_lsb;

    wstate_t       r_wstate;
    wstate_t       w_wnext;
    logic [WA-1:0] r_waddr;
    logic [7:0]    r_wlen;
    logic [7:0]    r_wcnt;
    logic          r_wdec;
    resp_t         r_bresp;
    resp_t         w_bfin;
    logic          w_win;

    rstate_t       r_rstate;
    rstate_t       w_rnext;
    logic [WA-1:0] r_raddr;
    logic [7:0]    r_rlen;
    logic [7:0]    r_rcnt;
    logic [DW-1:0] r_rdata;
    resp_t         r_rresp;
    logic          r_rlast;
    logic [WA-1:0] w_rd_word;
    logic          w_rin;
    logic [DW-1:0] w_mem_rdata;

    logic          w_awready;
    logic          w_wready;
    logic          w_arready;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_b_hs;
    logic          w_ar_hs;
    logic          w_r_hs;

    assign w_unused_lsb = ^{s_axi.AWADDR[OFF-1:0], s_axi.ARADDR[OFF-1:0]};

`ifdef AXI4FULL_SUB_BACKPRESSURE_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0],
                       r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_bp = r_lfsr[0];
`else
    assign w_bp = 1'b0;
`endif

    // readies stay low until the first edge after reset release
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign w_awready = r_live && (r_wstate == W_IDLE) && !w_bp;
    assign w_wready  = (r_wstate == W_DATA) && !w_bp;
    assign w_arready = r_live && (r_rstate == R_IDLE) && !w_bp;

    assign w_aw_hs = s_axi.AWVALID && w_awready;
    assign w_w_hs  = s_axi.WVALID && w_wready;
    assign w_b_hs  = (r_wstate == W_RESP) && s_axi.BREADY;
    assign w_ar_hs = s_axi.ARVALID && w_arready;
    assign w_r_hs  = (r_rstate == R_DATA) && s_axi.RREADY;

    // ---------------- write channel ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
            W_DATA:  if (w_w_hs && s_axi.WLAST) w_wnext = W_RESP;
            W_RESP:  if (w_b_hs) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    assign w_win = in_range(r_waddr);

    // response for the burst as of the current (last) beat; DECERR wins
    always_comb begin
        w_bfin = RESP_OKAY;
        if (r_wdec || !w_win) begin
            w_bfin = RESP_DECERR;
        end else if (r_wcnt != r_wlen) begin
            w_bfin = RESP_SLVERR;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_waddr <= '0;
            r_wlen  <= 8'd0;
            r_wcnt  <= 8'd0;
            r_wdec  <= 1'b0;
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_waddr <= s_axi.AWADDR[AW-1:OFF];
                r_wlen  <= s_axi.AWLEN;
                r_wcnt  <= 8'd0;
                r_wdec  <= 1'b0;
            end
            if (w_w_hs) begin
                r_waddr <= r_waddr + WA'(1);
                r_wcnt  <= r_wcnt + 8'd1;
                if (!w_win) begin
                    r_wdec <= 1'b1;
                end
                if (s_axi.WLAST) begin
                    r_bresp <= w_bfin;
                end
            end
            if (w_b_hs) begin
                r_bresp <= RESP_OKAY;
            end
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_rnext = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // the read port looks one beat ahead so RDATA can be registered
    assign w_rd_word = (r_rstate == R_IDLE) ? s_axi.ARADDR[AW-1:OFF]
                                            : r_raddr + WA'(1);
    assign w_rin = in_range(w_rd_word);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_raddr <= '0;
            r_rlen  <= 8'd0;
            r_rcnt  <= 8'd0;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
            r_rlast <= 1'b0;
        end else if (w_ar_hs) begin
            r_raddr <= w_rd_word;
            r_rlen  <= s_axi.ARLEN;
            r_rcnt  <= 8'd0;
            r_rdata <= w_rin ? w_mem_rdata : '0;
            r_rresp <= w_rin ? RESP_OKAY : RESP_DECERR;
            r_rlast <= (s_axi.ARLEN == 8'd0);
        end else if (w_r_hs) begin
            if (r_rlast) begin
                r_rdata <= '0;
                r_rresp <= RESP_OKAY;
                r_rlast <= 1'b0;
            end else begin
                r_raddr <= w_rd_word;
                r_rcnt  <= r_rcnt + 8'd1;
                r_rdata <= w_rin ? w_mem_rdata : '0;
                r_rresp <= w_rin ? RESP_OKAY : RESP_DECERR;
                r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
        end
    end

    axi4full_sub_bram #(
        .DW    (DW),
        .DEPTH (MEM_WORDS),
        .IW    (IW)
    ) u_bram (
        .i_clk   (S_AXI_ACLK),
        .i_we    (w_w_hs && w_win),
        .i_waddr (r_waddr[IW-1:0]),
        .i_wdata (s_axi.WDATA),
        .i_wstrb (s_axi.WSTRB),
        .i_raddr (w_rd_word[IW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign s_axi.AWREADY = w_awready;
    assign s_axi.WREADY  = w_wready;
    assign s_axi.BVALID  = (r_wstate == W_RESP);
    assign s_axi.BRESP   = r_bresp;
    assign s_axi.ARREADY = w_arready;
    assign s_axi.RVALID  = (r_rstate == R_DATA);
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;
    assign s_axi.RLAST   = r_rlast;

endmodule

// File: tb/tb_axi4full_sub_mem.sv
// tb_axi4full_sub_mem: self-checking bench for axi4full_sub_mem.
// Directed table, hand-written corner sequences and random bursts against a word-array model.
module tb_axi4full_sub_mem;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MW = 256;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  len;
        int          n;
        logic [3:0]  strb;
        logic [1:0]  eb;
        logic [1:0]  er;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4full_sub_mem_if #(.DW(DW), .AW(AW)) bus ();

    axi4full_sub_mem #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .MEM_WORDS          (MW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mdl [MW];
    beat_t       got_q[$];
    logic [31:0] wd_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    function automatic logic [41:0] outs();
        return {bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP, bus.ARREADY,
                bus.RDATA, bus.RRESP, bus.RLAST, bus.RVALID};
    endfunction

    function automatic int word_of(input logic [11:0] a, input int i);
        return ((int'(a) >> 2) + i) % 1024;
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [11:0] a, input int l, input int n);
        bit dec = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (word_of(a, i) >= MW) dec = 1'b1;
        end
        if (dec) return 2'b11;
        if (n != l + 1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic beat_t exp_beat(input logic [11:0] a, input int l, input int i);
        beat_t b;
        int w;
        w = word_of(a, i);
        b.l = (i == l);
        if (w >= MW) begin
            b.d = 32'd0;
            b.r = 2'b11;
        end else begin
            b.d = mdl[w];
            b.r = 2'b00;
        end
        return b;
    endfunction

    task automatic model_write(input logic [11:0] a, input int n, input logic [3:0] s);
        for (int i = 0; i < n; i++) begin
            int w;
            w = word_of(a, i);
            if (w < MW) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) mdl[w][8*b +: 8] = wd_q[i][8*b +: 8];
                end
            end
        end
    endtask

    // all tasks start and end on a falling edge
    task automatic write_burst(input logic [11:0] a, input logic [7:0] l,
                               input int n, input logic [3:0] s,
                               output logic [1:0] resp);
        int t;
        chk("wready_pre_aw", 64'(bus.WREADY), 64'd0);
        bus.AWADDR  = a;
        bus.AWLEN   = l;
        bus.AWVALID = 1'b1;
        t = 0;
        while (!bus.AWREADY && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) tmo("aw_hs");
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.WDATA  = wd_q[i];
            bus.WSTRB  = s;
            bus.WLAST  = (i == n - 1);
            bus.WVALID = 1'b1;
            t = 0;
            while (!bus.WREADY && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) tmo("w_hs");
            chk("b_early", 64'(bus.BVALID), 64'd0);
            @(negedge clk);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        bus.BREADY = 1'b1;
        t = 0;
        while (!bus.BVALID && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) tmo("b_hs");
        resp = bus.BRESP;
        @(negedge clk);
        bus.BREADY = 1'b0;
    endtask

    task automatic read_burst(input logic [11:0] a, input logic [7:0] l, input int stall);
        int   t;
        logic [34:0] snap;
        bit   stalled;
        got_q.delete();
        stalled = 1'b0;
        bus.ARADDR  = a;
        bus.ARLEN   = l;
        bus.ARVALID = 1'b1;
        t = 0;
        while (!bus.ARREADY && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) tmo("ar_hs");
        @(negedge clk);
        bus.ARVALID = 1'b0;
        chk("r_latency", 64'(bus.RVALID), 64'd1);
        t = 0;
        while (t < 600) begin
            if (bus.RVALID && !stalled && got_q.size() == stall) begin
                snap = {bus.RDATA, bus.RRESP, bus.RLAST};
                bus.RREADY = 1'b0;
                stalled = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("r_hold", 64'({bus.RVALID, bus.RDATA, bus.RRESP, bus.RLAST}),
                        64'({1'b1, snap}));
                end
            end
            bus.RREADY = 1'b1;
            if (bus.RVALID) begin
                got_q.push_back({bus.RDATA, bus.RRESP, bus.RLAST});
                if (bus.RLAST || got_q.size() > 300) break;
            end
            @(negedge clk);
            t++;
        end
        if (t >= 600) tmo("r_last");
        @(negedge clk);
        bus.RREADY = 1'b0;
        chk("r_idle_zero", 64'({bus.RVALID, bus.RDATA, bus.RRESP, bus.RLAST}), 64'd0);
    endtask

    task automatic cmp_read(input string nm, input logic [11:0] a, input logic [7:0] l);
        chk({nm, "_beats"}, 64'(got_q.size()), 64'(int'(l) + 1));
        for (int i = 0; i <= int'(l) && i < got_q.size(); i++) begin
            chk(nm, 64'(got_q[i]), 64'(exp_beat(a, int'(l), i)));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[9];
        logic [1:0]  resp;
        logic [11:0] a;
        logic [7:0]  l;
        int          n;
        int          t;
        logic [3:0]  s;

        vt[0] = '{12'h040, 8'd0, 1, 4'hF, 2'b00, 2'b00};
        vt[1] = '{12'h080, 8'd7, 8, 4'h5, 2'b00, 2'b00};
        vt[2] = '{12'h020, 8'd3, 2, 4'hF, 2'b10, 2'b00};
        vt[3] = '{12'h400, 8'd0, 1, 4'hF, 2'b11, 2'b11};
        vt[4] = '{12'h3FC, 8'd1, 2, 4'hF, 2'b11, 2'b00};
        vt[5] = '{12'h400, 8'd1, 1, 4'hF, 2'b11, 2'b11};
        vt[6] = '{12'hFFC, 8'd1, 2, 4'hF, 2'b11, 2'b11};
        vt[7] = '{12'h0C3, 8'd2, 3, 4'hA, 2'b00, 2'b00};
        vt[8] = '{12'h100, 8'd2, 4, 4'hF, 2'b10, 2'b00};

        bus.AWADDR = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        // reset
        repeat (3) @(negedge clk);
        chk("rst_outs", 64'(outs()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'({bus.AWREADY, bus.ARREADY}), 64'(2'b11));

        // preload whole array
        wd_q.delete();
        for (int i = 0; i < MW; i++) wd_q.push_back($urandom);
        write_burst(12'h000, 8'd255, MW, 4'hF, resp);
        chk("fill_bresp", 64'(resp), 64'd0);
        model_write(12'h000, MW, 4'hF);

        // basic burst with data 1..4
        wd_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        write_burst(12'h010, 8'd3, 4, 4'hF, resp);
        chk("t2_bresp", 64'(resp), 64'd0);
        model_write(12'h010, 4, 4'hF);
        read_burst(12'h010, 8'd3, -1);
        chk("t2_beats", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            chk("t2_rdata", 64'(got_q[i].d), 64'(i + 1));
            chk("t2_rresp", 64'(got_q[i].r), 64'd0);
            chk("t2_rlast", 64'(got_q[i].l), 64'(i == 3));
        end

        // stall on beat 2
        read_burst(12'h010, 8'd3, 2);
        cmp_read("t3_rd", 12'h010, 8'd3);

        // directed table
        for (int k = 0; k < 9; k++) begin
            wd_q.delete();
            for (int i = 0; i < vt[k].n; i++) wd_q.push_back($urandom);
            write_burst(vt[k].addr, vt[k].len, vt[k].n, vt[k].strb, resp);
            chk("tbl_bresp", 64'(resp), 64'(vt[k].eb));
            model_write(vt[k].addr, vt[k].n, vt[k].strb);
            read_burst(vt[k].addr, vt[k].len, -1);
            if (got_q.size() > 0) chk("tbl_rresp0", 64'(got_q[0].r), 64'(vt[k].er));
            cmp_read("tbl_rd", vt[k].addr, vt[k].len);
        end

        // reset in the middle of a read burst
        bus.ARADDR  = 12'h010;
        bus.ARLEN   = 8'd3;
        bus.ARVALID = 1'b1;
        t = 0;
        while (!bus.ARREADY && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) tmo("t6_ar_hs");
        @(negedge clk);
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_beat2", 64'({bus.RVALID, bus.RDATA}), 64'({1'b1, mdl[6]}));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", 64'(outs()), 64'd0);
        bus.RREADY = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_burst(12'h010, 8'd3, -1);
        cmp_read("t6_reread", 12'h010, 8'd3);

        // random bursts
        for (int k = 0; k < 24; k++) begin
            a = 12'($urandom_range(0, 12'h4FF));
            if ($urandom_range(0, 7) == 0) a = 12'($urandom_range(0, 12'hFFF));
            l = 8'($urandom_range(0, 7));
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : int'(l) + 1;
            s = 4'($urandom_range(1, 15));
            wd_q.delete();
            for (int i = 0; i < n; i++) wd_q.push_back($urandom);
            write_burst(a, l, n, s, resp);
            chk("rnd_bresp", 64'(resp), 64'(exp_bresp(a, int'(l), n)));
            model_write(a, n, s);
            read_burst(a, l, int'($urandom_range(0, int'(l) + 2)));
            cmp_read("rnd_rd", a, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
